// File: rtl/hash_msg_feeder.sv
// hash_msg_feeder
//   Byte-stream front end for the hash core. Buffers one message from an
//   upstream valid/ready byte source, counts its length, then replays it to
//   the hash as a contiguous M_valid burst with counter = message length.
//   After the burst it waits for a rising hash_ready before taking the next
//   message. Overlong messages are dropped (err_overflow). If the hash never
//   answers, err_timeout is raised. Both error flags are sticky until rst.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_data/in_last/in_nobyte/in_ready   upstream byte stream
//   M_valid/message/counter   registered burst to the hash
//   hash_ready        digest-valid from the hash (rising edge ends a message)
//   busy              state != IDLE
//   err_overflow      sticky: message longer than DEPTH was dropped
//   err_timeout       sticky: no hash_ready rise within TIMEOUT cycles
module hash_msg_feeder #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        in_nobyte,
  output logic        in_ready,
  output logic        M_valid,
  output logic [7:0]  message,
  output logic [63:0] counter,
  input  logic        hash_ready,
  output logic        busy,
  output logic        err_overflow,
  output logic        err_timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, FILL, DROP, SEND, WAIT_HASH} state_t;

  state_t        state, state_n;
  logic [LW-1:0] len, len_n, len_inc;
  logic [LW-1:0] rd, rd_n;
  logic [TW-1:0] timer, timer_n;
  logic [7:0]    mem [DEPTH];
  logic          hr_q, hr_rise, accept, wr_en;
  logic          mv_n, ovf_n, tmo_n, rdy_n;
  logic [7:0]    msg_n;
  logic [63:0]   cnt_n;

  assign accept  = in_valid & in_ready;
  assign hr_rise = hash_ready & ~hr_q;
  assign busy    = (state != IDLE);
  assign len_inc = len + LW'(1);

  always_comb begin
    state_n = state;
    len_n   = len;
    rd_n    = rd;
    timer_n = timer;
    mv_n    = M_valid;
    msg_n   = message;
    cnt_n   = counter;
    ovf_n   = err_overflow;
    tmo_n   = err_timeout;
    wr_en   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (in_last && in_nobyte) begin
          // zero-length message: one dummy beat of 8'h00 with counter 0
          state_n = SEND;
          len_n   = '0;
          rd_n    = LW'(1);
          mv_n    = 1'b1;
          msg_n   = 8'h00;
          cnt_n   = '0;
        end else begin
          wr_en = 1'b1;
          len_n = len_inc;
          if (in_last) begin
            // single-byte message: buffer not yet written, forward the byte
            state_n = SEND;
            rd_n    = LW'(1);
            mv_n    = 1'b1;
            msg_n   = in_data;
            cnt_n   = 64'(len_inc);
          end else begin
            state_n = FILL;
          end
        end
      end
      FILL: if (accept) begin
        if (len == LW'(DEPTH)) begin
          ovf_n   = 1'b1;
          len_n   = '0;
          state_n = in_last ? IDLE : DROP;
        end else begin
          wr_en = 1'b1;
          len_n = len_inc;
          if (in_last) begin
            // first beat goes out on the same edge the last byte lands
            state_n = SEND;
            rd_n    = LW'(1);
            mv_n    = 1'b1;
            msg_n   = mem[0];
            cnt_n   = 64'(len_inc);
          end
        end
      end
      DROP: if (accept && in_last) begin
        state_n = IDLE;
        len_n   = '0;
      end
      SEND: begin
        // rd starts at 1, so len==0 and len==1 both give exactly one beat
        if (rd >= len) begin
          mv_n    = 1'b0;
          state_n = WAIT_HASH;
          timer_n = '0;
        end else begin
          msg_n = mem[rd[AW-1:0]];
          rd_n  = rd + LW'(1);
        end
      end
      WAIT_HASH: begin
        if (hr_rise) begin
          state_n = IDLE;
          len_n   = '0;
          timer_n = '0;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          tmo_n   = 1'b1;
          state_n = IDLE;
          len_n   = '0;
          timer_n = '0;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    rdy_n = (state_n == IDLE) || (state_n == FILL) || (state_n == DROP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      len          <= '0;
      rd           <= '0;
      timer        <= '0;
      M_valid      <= 1'b0;
      message      <= '0;
      counter      <= '0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
      in_ready     <= 1'b0;
      hr_q         <= 1'b0;
    end else begin
      state        <= state_n;
      len          <= len_n;
      rd           <= rd_n;
      timer        <= timer_n;
      M_valid      <= mv_n;
      message      <= msg_n;
      counter      <= cnt_n;
      err_overflow <= ovf_n;
      err_timeout  <= tmo_n;
      in_ready     <= rdy_n;
      hr_q         <= hash_ready;
    end
  end

  // payload storage needs no reset; wr_en only fires while len < DEPTH
  always_ff @(posedge clk) begin
    if (wr_en) mem[len[AW-1:0]] <= in_data;
  end
endmodule
